// File: rtl/debouncer_multi.sv
// N-channel debouncer: updates O[n] only after I[n] holds one level for STABLE_CYCLES clocks.
// Define DEBOUNCE_SYNC_EN to add a two-flop synchroniser in front of every channel.
module debouncer_multi #(
    parameter int               WIDTH         = 2,
    parameter int               STABLE_CYCLES = 20,
    parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             ANY_CHANGE
);

    localparam int            CW   = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

    if (WIDTH < 1 || STABLE_CYCLES < 2) begin : g_bad_param
        $error("debouncer_multi: WIDTH must be >= 1 and STABLE_CYCLES >= 2");
    end

    logic [WIDTH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= INIT;
            sync2_q <= INIT;
        end else begin
            sync1_q <= I;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = I;
`endif

    logic [WIDTH-1:0] iv_q,   iv_d;
    logic [WIDTH-1:0] o_q,    o_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q,  any_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A sample that differs from the last one restarts the run; a full run
    // commits the level and the counter then parks at its maximum.
    always_comb begin
        iv_d = iv_q;
        o_d  = o_q;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = cnt_q[n];
            if (s[n] != iv_q[n]) begin
                iv_d[n]  = s[n];
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CMAX) begin
                o_d[n] = iv_q[n];
            end else begin
                cnt_d[n] = cnt_q[n] + 1'b1;
            end
        end
        rise_d = o_d & ~o_q;
        fall_d = ~o_d & o_q;
        any_d  = |(rise_d | fall_d);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            iv_q   <= INIT;
            o_q    <= INIT;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            iv_q   <= iv_d;
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign O          = o_q;
    assign RISE       = rise_q;
    assign FALL       = fall_q;
    assign ANY_CHANGE = any_q;

endmodule
